// File: rtl/cube_scan_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cube_scan_ctl
// Purpose  : Double-banked cube RAM read scheduler. Swaps banks on completed
//            frames, scans layer/pixel order into the NeoPixel encoder and
//            enforces the WS2812 latch gap after each frame.
// Revision : 1.0  initial release
// ============================================================================
module cube_scan_ctl #(
    parameter int LAYERS     = 8,
    parameter int PIXELS     = 64,
    parameter int RST_CYCLES = 4000,
    parameter int LAYER_W    = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    parameter int ADDR_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    parameter int CNT_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               frame_rdy_in,
    output logic               wr_bank_out,
    output logic               rd_bank_out,
    output logic               rd_en_out,
    output logic [LAYER_W-1:0] rd_layer_out,
    output logic [ADDR_W-1:0]  rd_addr_out,
    output logic               pix_vld_out,
    input  logic               pix_rdy_in,
    output logic               busy_out,
    output logic               frame_done_out,
    output logic               drop_out
);

    localparam logic [LAYER_W-1:0] C_LAST_LAYER = LAYER_W'(LAYERS - 1);
    localparam logic [ADDR_W-1:0]  C_LAST_ADDR  = ADDR_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]   C_GAP_END    = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_pending;
    logic               r_wr_bank;
    logic [LAYER_W-1:0] r_layer;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rd_en;
    logic               r_pix_vld;
    logic               r_frame_done;
    logic               r_drop;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_layer      <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_rd_en      <= 1'b0;
            r_pix_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;

            // Outside IDLE a new frame can only be queued; a second one overwrites
            // the same write bank, so the earlier frame is reported as dropped.
            if ((r_state != S_IDLE) && frame_rdy_in) begin
                if (r_pending) begin
                    r_drop <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_wr_bank <= ~r_wr_bank;
                        r_pending <= 1'b0;
                        r_layer   <= '0;
                        r_addr    <= '0;
                        r_rd_en   <= 1'b1;
                        r_state   <= S_READ;
                    end else if (frame_rdy_in) begin
                        r_pending <= 1'b1;
                    end
                end

                S_READ: begin
                    r_rd_en   <= 1'b0;
                    r_pix_vld <= 1'b1;
                    r_state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (pix_rdy_in) begin
                        r_pix_vld <= 1'b0;
                        if ((r_layer == C_LAST_LAYER) && (r_addr == C_LAST_ADDR)) begin
                            r_frame_done <= 1'b1;
                            r_cnt        <= '0;
                            r_layer      <= '0;
                            r_addr       <= '0;
                            r_state      <= S_LATCH;
                        end else if (r_addr == C_LAST_ADDR) begin
                            r_addr  <= '0;
                            r_layer <= r_layer + 1'b1;
                            r_rd_en <= 1'b1;
                            r_state <= S_READ;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_rd_en <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end

                S_LATCH: begin
                    if (r_cnt == C_GAP_END) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_bank_out    = r_wr_bank;
    assign rd_bank_out    = ~r_wr_bank;
    assign rd_en_out      = r_rd_en;
    assign rd_layer_out   = r_layer;
    assign rd_addr_out    = r_addr;
    assign pix_vld_out    = r_pix_vld;
    assign frame_done_out = r_frame_done;
    assign drop_out       = r_drop;
    // An IDLE cycle with a queued frame is the swap cycle, which counts as busy.
    assign busy_out       = (r_state != S_IDLE) || r_pending;

endmodule
`default_nettype wire

// File: tb/tb_cube_scan_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cube_scan_ctl
// Purpose  : Self-checking bench for cube_scan_ctl against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cube_scan_ctl;

    localparam int LAYERS = 8;
    localparam int PIXELS = 64;
    localparam int RSTC   = 16;
    localparam int NPIX   = LAYERS * PIXELS;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       frame_rdy_in;
    logic       pix_rdy_in;
    logic       wr_bank_out, rd_bank_out, rd_en_out, pix_vld_out;
    logic       busy_out, frame_done_out, drop_out;
    logic [2:0] rd_layer_out;
    logic [5:0] rd_addr_out;

    int checks = 0;
    int errors = 0;

    // Frame-level model state
    bit exp_wr      = 1'b0;
    bit exp_pending = 1'b0;
    int handshakes  = 0;

    cube_scan_ctl #(
        .LAYERS     (LAYERS),
        .PIXELS     (PIXELS),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .frame_rdy_in   (frame_rdy_in),
        .wr_bank_out    (wr_bank_out),
        .rd_bank_out    (rd_bank_out),
        .rd_en_out      (rd_en_out),
        .rd_layer_out   (rd_layer_out),
        .rd_addr_out    (rd_addr_out),
        .pix_vld_out    (pix_vld_out),
        .pix_rdy_in     (pix_rdy_in),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .drop_out       (drop_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_wr_bank", 32'(wr_bank_out), 0);
        check("rst_rd_bank", 32'(rd_bank_out), 1);
        check("rst_rd_en",   32'(rd_en_out), 0);
        check("rst_vld",     32'(pix_vld_out), 0);
        check("rst_busy",    32'(busy_out), 0);
        check("rst_done",    32'(frame_done_out), 0);
        check("rst_drop",    32'(drop_out), 0);
        check("rst_layer",   32'(rd_layer_out), 0);
        check("rst_addr",    32'(rd_addr_out), 0);
    endtask

    // Queue a frame from IDLE and follow it through the swap cycle into READ.
    task automatic start_frame(input bit second_pulse);
        frame_rdy_in = 1'b1;
        tick();
        frame_rdy_in = second_pulse;
        check("swap_wait_bank", 32'(wr_bank_out), 32'(exp_wr));
        check("swap_cycle_busy", 32'(busy_out), 1);
        tick();
        frame_rdy_in = 1'b0;
        exp_wr = ~exp_wr;
        exp_pending = 1'b0;
        check("swap_wr_bank", 32'(wr_bank_out), 32'(exp_wr));
        check("swap_rd_bank", 32'(rd_bank_out), 32'(!exp_wr));
        check("swap_drop", 32'(drop_out), 0);
        check("swap_rd_en", 32'(rd_en_out), 1);
    endtask

    // Walk one frame pixel by pixel from the first READ cycle. Frame pulses are
    // injected on the READ->WAIT edge of pixels p1/p2; stop_k leaves the scan in WAIT.
    task automatic scan(input int stall, input int p1, input int p2, input int stop_k);
        for (int k = 0; k < NPIX; k++) begin
            int  n;
            bit  rdy;
            bit  pulsed;
            check("rd_en", 32'(rd_en_out), 1);
            check("rd_layer", 32'(rd_layer_out), k / PIXELS);
            check("rd_addr", 32'(rd_addr_out), k % PIXELS);
            pulsed       = (k == p1) || (k == p2);
            frame_rdy_in = pulsed;
            pix_rdy_in   = 1'($urandom_range(1));
            tick();
            frame_rdy_in = 1'b0;
            if (pulsed) begin
                check("drop_pulse", 32'(drop_out), 32'(exp_pending));
                exp_pending = 1'b1;
            end
            check("vld_after_read", 32'(pix_vld_out), 1);
            check("rd_en_in_wait", 32'(rd_en_out), 0);
            if (k == stop_k) return;
            n = 0;
            do begin
                rdy = (int'($urandom_range(99)) >= stall) || (n >= 50);
                pix_rdy_in = rdy;
                tick();
                n++;
                if (!rdy) begin
                    check("stall_vld", 32'(pix_vld_out), 1);
                    check("stall_addr", 32'(rd_addr_out), k % PIXELS);
                    check("stall_layer", 32'(rd_layer_out), k / PIXELS);
                end
            end while (!rdy);
            handshakes++;
            pix_rdy_in = 1'b0;
            check("vld_drop", 32'(pix_vld_out), 0);
            check("hs_drop", 32'(drop_out), 0);
            check("frame_done", 32'(frame_done_out), (k == NPIX - 1) ? 1 : 0);
        end
        check("latch_busy0", 32'(busy_out), 1);
        check("latch_rd_en0", 32'(rd_en_out), 0);
    endtask

    // Called on the first latch cycle (frame_done visible).
    task automatic latch(input bit expect_swap);
        for (int i = 1; i < RSTC; i++) begin
            tick();
            check("latch_busy", 32'(busy_out), 1);
            check("latch_rd_en", 32'(rd_en_out), 0);
            check("latch_vld", 32'(pix_vld_out), 0);
            check("latch_done", 32'(frame_done_out), 0);
        end
        tick();
        check("gap_end_bank", 32'(wr_bank_out), 32'(exp_wr));
        check("gap_end_busy", 32'(busy_out), expect_swap ? 1 : 0);
        check("gap_end_rd_en", 32'(rd_en_out), 0);
        if (expect_swap) begin
            tick();
            exp_wr = ~exp_wr;
            exp_pending = 1'b0;
            check("queued_swap_bank", 32'(wr_bank_out), 32'(exp_wr));
            check("queued_swap_rd_en", 32'(rd_en_out), 1);
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        frame_rdy_in = 1'b0;
        pix_rdy_in   = 1'b0;
        tick();
        check_reset_vals();
        rst_n_in = 1'b1;
        tick();
        check("idle_busy", 32'(busy_out), 0);

        // Single frame, no backpressure: one read every two cycles
        handshakes = 0;
        start_frame(1'b0);
        scan(0, -1, -1, -1);
        check("hs_count_a", handshakes, NPIX);
        latch(1'b0);

        // Random backpressure
        handshakes = 0;
        start_frame(1'b0);
        scan(45, -1, -1, -1);
        check("hs_count_b", handshakes, NPIX);
        latch(1'b0);

        // Two frame pulses during a scan: one drop, one deferred swap
        start_frame(1'b0);
        scan(20, 100, 300, -1);
        latch(1'b1);
        scan(0, -1, -1, -1);
        latch(1'b0);

        // Pulse landing on the swap cycle is absorbed
        start_frame(1'b1);
        scan(10, -1, -1, -1);
        latch(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_second_scan", 32'(rd_en_out | busy_out), 0);
        end

        // Reset mid-scan at L3A17 in WAIT, then restart from L0A0
        start_frame(1'b0);
        scan(30, -1, -1, 3 * PIXELS + 17);
        check("pre_rst_vld", 32'(pix_vld_out), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_vals();
        exp_wr = 1'b0;
        exp_pending = 1'b0;
        tick();
        rst_n_in = 1'b1;
        tick();
        handshakes = 0;
        start_frame(1'b0);
        check("restart_bank", 32'(wr_bank_out), 1);
        scan(25, -1, -1, -1);
        check("hs_count_c", handshakes, NPIX);
        latch(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
